multi_dataflow_tile_seq: RTL

Tile sequencer between the multi_dataflow control FSM and the streamers/engine. On a start pulse it latches one job's frame geometry and walks the frame in raster tile order. For each tile it issues one input-stream request and one output-stream request, pulses the engine start, then waits for both engine-done and output-stream-done before advancing. When the last tile retires it pulses done.

---
 rtl/multi_dataflow_tile_seq_pkg.sv | 28 ++
 rtl/multi_dataflow_tile_seq_addr.sv | 53 +++++
 rtl/multi_dataflow_tile_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multi_dataflow_tile_seq_pkg.sv
// multi_dataflow_package
// Shared types for the multi_dataflow tile sequencer: the sequencer state
// encoding, the per-tile stream request layout and the default element size.
package multi_dataflow_package;

    localparam int MDF_ELEM_BYTES_LOG2 = 2;   // 4-byte words
    localparam int MDF_ADDR_W          = 32;
    localparam int MDF_DIM_W           = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_KICK     = 3'd4,
        S_RUN      = 3'd5,
        S_NEXT     = 3'd6,
        S_FINISH   = 3'd7
    } tile_seq_state_t;

    typedef struct packed {
        logic [MDF_ADDR_W-1:0] addr;
        logic [MDF_DIM_W-1:0]  line_len;
        logic [MDF_DIM_W-1:0]  n_lines;
        logic [MDF_ADDR_W-1:0] line_stride;
    } tile_req_t;

endpackage

// File: rtl/multi_dataflow_tile_seq_addr.sv
// multi_dataflow_tile_addr
// Registered tile address / clipping unit. When en_i is high it captures the
// byte addresses of tile origin (x_i, y_i) in both frames and the tile size
// clipped to the frame edge; results appear one cycle later.
// Ports: clk_i, rst_i (sync, active-high), en_i, frame geometry inputs,
//        x_i/y_i tile origin, in_addr_o/out_addr_o, line_len_o, n_lines_o.
module multi_dataflow_tile_addr #(
    parameter int ADDR_W          = 32,
    parameter int DIM_W           = 16,
    parameter int ELEM_BYTES_LOG2 = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] base_in_i,
    input  logic [ADDR_W-1:0] base_out_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic [DIM_W-1:0]  height_i,
    input  logic [DIM_W-1:0]  tile_w_i,
    input  logic [DIM_W-1:0]  tile_h_i,
    input  logic [DIM_W-1:0]  x_i,
    input  logic [DIM_W-1:0]  y_i,
    output logic [ADDR_W-1:0] in_addr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DIM_W-1:0]  line_len_o,
    output logic [DIM_W-1:0]  n_lines_o
);

    logic [ADDR_W-1:0] w_off;
    logic [DIM_W-1:0]  w_rem_w;
    logic [DIM_W-1:0]  w_rem_h;

    // Element offset in ADDR_W bits; overflow wraps silently.
    assign w_off   = (ADDR_W'(y_i) * ADDR_W'(width_i) + ADDR_W'(x_i)) << ELEM_BYTES_LOG2;
    // Origins are always inside the frame, so these never underflow.
    assign w_rem_w = width_i - x_i;
    assign w_rem_h = height_i - y_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_addr_o  <= '0;
            out_addr_o <= '0;
            line_len_o <= '0;
            n_lines_o  <= '0;
        end else if (en_i) begin
            in_addr_o  <= base_in_i + w_off;
            out_addr_o <= base_out_i + w_off;
            line_len_o <= (tile_w_i < w_rem_w) ? tile_w_i : w_rem_w;
            n_lines_o  <= (tile_h_i < w_rem_h) ? tile_h_i : w_rem_h;
        end
    end

endmodule

// File: rtl/multi_dataflow_tile_seq.sv
// multi_dataflow_tile_seq
// Walks one frame in raster tile order. Per tile: issue input and output
// stream requests, pulse the engine, wait for engine-done and output-done,
// then advance. Pulses done_o after the last tile.
// Ports: clk_i/rst_i/clear_i, start_i + frame geometry, in/out request
//        handshakes with shared tile geometry, eng_start_o, eng_done_i,
//        out_done_i, busy_o, done_o, cfg_err_o, tile_x_o/tile_y_o.
module multi_dataflow_tile_seq
    import multi_dataflow_package::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DIM_W           = 16,
    parameter int ELEM_BYTES_LOG2 = MDF_ELEM_BYTES_LOG2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_in_i,
    input  logic [ADDR_W-1:0] base_out_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic [DIM_W-1:0]  height_i,
    input  logic [DIM_W-1:0]  tile_w_i,
    input  logic [DIM_W-1:0]  tile_h_i,
    output logic              in_req_valid_o,
    input  logic              in_req_ready_i,
    output logic              out_req_valid_o,
    input  logic              out_req_ready_i,
    output logic [ADDR_W-1:0] in_addr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DIM_W-1:0]  req_line_len_o,
    output logic [DIM_W-1:0]  req_n_lines_o,
    output logic [ADDR_W-1:0] req_line_stride_o,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    input  logic              out_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [DIM_W-1:0]  tile_x_o,
    output logic [DIM_W-1:0]  tile_y_o
);

    tile_seq_state_t   r_state;
    logic [ADDR_W-1:0] r_base_in, r_base_out, r_stride;
    logic [DIM_W-1:0]  r_width, r_height, r_tile_w, r_tile_h;
    logic [DIM_W-1:0]  r_x, r_y;
    logic              r_in_vld, r_out_vld, r_eng_seen, r_out_seen, r_cfg_err;

    logic              w_rst, w_cfg_bad, w_x_wrap, w_last, w_addr_en;
    logic              w_eng_seen, w_out_seen, w_in_pend, w_out_pend;
    logic [DIM_W:0]    w_x_sum, w_y_sum;
    logic [DIM_W-1:0]  w_x_nx, w_y_nx, w_ax, w_ay;

    assign w_rst     = rst_i | clear_i;
    assign w_cfg_bad = (r_width == '0) | (r_height == '0) | (r_tile_w == '0) | (r_tile_h == '0);

    // Next tile origin; one extra bit so x+tile_w / y+tile_h never wrap.
    assign w_x_sum  = {1'b0, r_x} + {1'b0, r_tile_w};
    assign w_y_sum  = {1'b0, r_y} + {1'b0, r_tile_h};
    assign w_x_wrap = w_x_sum >= {1'b0, r_width};
    assign w_last   = w_x_wrap && (w_y_sum >= {1'b0, r_height});
    assign w_x_nx   = w_x_wrap ? '0 : w_x_sum[DIM_W-1:0];
    assign w_y_nx   = w_x_wrap ? w_y_sum[DIM_W-1:0] : r_y;

    // Tile geometry is precomputed in the cycle before ISSUE.
    assign w_addr_en = ((r_state == S_CHECK) && !w_cfg_bad) || ((r_state == S_NEXT) && !w_last);
    assign w_ax      = (r_state == S_CHECK) ? '0 : w_x_nx;
    assign w_ay      = (r_state == S_CHECK) ? '0 : w_y_nx;

    // Same-cycle completion pulses count as seen.
    assign w_eng_seen = r_eng_seen | eng_done_i;
    assign w_out_seen = r_out_seen | out_done_i;
    assign w_in_pend  = r_in_vld  & ~in_req_ready_i;
    assign w_out_pend = r_out_vld & ~out_req_ready_i;

    multi_dataflow_tile_addr #(
        .ADDR_W(ADDR_W), .DIM_W(DIM_W), .ELEM_BYTES_LOG2(ELEM_BYTES_LOG2)
    ) u_addr (
        .clk_i(clk_i), .rst_i(w_rst), .en_i(w_addr_en),
        .base_in_i(r_base_in), .base_out_i(r_base_out),
        .width_i(r_width), .height_i(r_height),
        .tile_w_i(r_tile_w), .tile_h_i(r_tile_h),
        .x_i(w_ax), .y_i(w_ay),
        .in_addr_o(in_addr_o), .out_addr_o(out_addr_o),
        .line_len_o(req_line_len_o), .n_lines_o(req_n_lines_o)
    );

    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state    <= S_IDLE;
            r_base_in  <= '0;
            r_base_out <= '0;
            r_stride   <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_tile_w   <= '0;
            r_tile_h   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_in_vld   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_eng_seen <= 1'b0;
            r_out_seen <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_base_in  <= base_in_i;
                    r_base_out <= base_out_i;
                    r_width    <= width_i;
                    r_height   <= height_i;
                    r_tile_w   <= tile_w_i;
                    r_tile_h   <= tile_h_i;
                    r_stride   <= ADDR_W'(width_i) << ELEM_BYTES_LOG2;
                    r_cfg_err  <= 1'b0;
                    r_state    <= S_CHECK;
                end
                S_CHECK: if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                    r_state   <= S_FINISH;
                end else begin
                    r_x        <= '0;
                    r_y        <= '0;
                    r_in_vld   <= 1'b1;
                    r_out_vld  <= 1'b1;
                    r_eng_seen <= 1'b0;
                    r_out_seen <= 1'b0;
                    r_state    <= S_ISSUE;
                end
                S_ISSUE, S_WAIT_ACK: begin
                    if (in_req_ready_i)  r_in_vld  <= 1'b0;
                    if (out_req_ready_i) r_out_vld <= 1'b0;
                    r_state <= (!w_in_pend && !w_out_pend) ? S_KICK : S_WAIT_ACK;
                end
                S_KICK: r_state <= S_RUN;
                S_RUN: begin
                    r_eng_seen <= w_eng_seen;
                    r_out_seen <= w_out_seen;
                    if (w_eng_seen && w_out_seen) r_state <= S_NEXT;
                end
                S_NEXT: if (w_last) begin
                    r_state <= S_FINISH;
                end else begin
                    r_x        <= w_x_nx;
                    r_y        <= w_y_nx;
                    r_in_vld   <= 1'b1;
                    r_out_vld  <= 1'b1;
                    r_eng_seen <= 1'b0;
                    r_out_seen <= 1'b0;
                    r_state    <= S_ISSUE;
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign in_req_valid_o    = r_in_vld;
    assign out_req_valid_o   = r_out_vld;
    assign req_line_stride_o = r_stride;
    assign eng_start_o       = (r_state == S_KICK);
    assign done_o            = (r_state == S_FINISH);
    assign busy_o            = (r_state != S_IDLE);
    assign cfg_err_o         = r_cfg_err;
    assign tile_x_o          = r_x;
    assign tile_y_o          = r_y;

endmodule
